// File: rtl/regfile_defs.sv
// Register-code and handshake-state constants shared by the register-file writer and the bus read mux.
// Pure constants: no latency, no flow control.
// Code 0 selects nothing; codes 1..16 select r0..r15; 17..31 are invalid.
package regfile_defs;

    localparam logic [4:0] CODE_NONE = 5'd0;
    localparam logic [4:0] CODE_R0   = 5'd1;
    localparam logic [4:0] CODE_R1   = 5'd2;
    localparam logic [4:0] CODE_R2   = 5'd3;
    localparam logic [4:0] CODE_R3   = 5'd4;
    localparam logic [4:0] CODE_R4   = 5'd5;
    localparam logic [4:0] CODE_R5   = 5'd6;
    localparam logic [4:0] CODE_R6   = 5'd7;
    localparam logic [4:0] CODE_R7   = 5'd8;
    localparam logic [4:0] CODE_R8   = 5'd9;
    localparam logic [4:0] CODE_R9   = 5'd10;
    localparam logic [4:0] CODE_R10  = 5'd11;
    localparam logic [4:0] CODE_R11  = 5'd12;
    localparam logic [4:0] CODE_R12  = 5'd13;
    localparam logic [4:0] CODE_R13  = 5'd14;
    localparam logic [4:0] CODE_R14  = 5'd15;
    localparam logic [4:0] CODE_R15  = 5'd16;
    localparam logic [4:0] CODE_MAX  = 5'd16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

endpackage

// File: rtl/reg16_cell.sv
// Single register-file entry: loads d_i when ld_i is high, clears asynchronously on reset.
// Latency: one edge from load to q_o. No flow control.
module reg16_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile_writer.sv
// Write side of the 16 x 16-bit register file: one bus capture per four-phase req/ack handshake.
// Latency: target register and wr_ack/err update on the edge that samples wr_req high in IDLE.
// Backpressure: new requests are taken only from IDLE; wr_req must drop before the next write.
module regfile_writer
    import regfile_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       control,
    input  logic [WIDTH-1:0] bus,
    input  logic             wr_req,
    output logic             wr_ack,
    output logic             err,
    input  logic             clr_flags,
    output logic [NREGS-1:0] written,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15
);

    logic [0:0]       state_q, state_d;
    logic             wr_ack_q, wr_ack_d;
    logic             err_q, err_d;
    logic [NREGS-1:0] written_q, written_d;
    logic [NREGS-1:0] sel;
    logic [NREGS-1:0] ld;
    logic             accept;
    logic             code_vld;
    logic [WIDTH-1:0] reg_q [NREGS];

    // One-hot decode of the code; codes 0 and 17..31 leave every bit low.
    for (genvar g = 0; g < NREGS; g++) begin : g_dec
        assign sel[g] = (control == 5'(g + 1));
    end

    assign code_vld = |sel;
    assign accept   = (state_q == ST_IDLE) && wr_req;
    assign ld       = accept ? sel : '0;

    always_comb begin
        state_d   = state_q;
        wr_ack_d  = wr_ack_q;
        err_d     = err_q;
        written_d = clr_flags ? '0 : written_q;
        written_d = written_d | ld;
        if (state_q == ST_IDLE) begin
            if (wr_req) begin
                state_d  = ST_ACK;
                wr_ack_d = 1'b1;
                err_d    = !code_vld;
            end
        end else if (!wr_req) begin
            state_d  = ST_IDLE;
            wr_ack_d = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ack_q  <= wr_ack_d;
            err_q     <= err_d;
            written_q <= written_d;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_cell
        reg16_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .ld_i  (ld[g]),
            .d_i   (bus),
            .q_o   (reg_q[g])
        );
    end

    assign wr_ack  = wr_ack_q;
    assign err     = err_q;
    assign written = written_q;

    assign r0  = reg_q[0];
    assign r1  = reg_q[1];
    assign r2  = reg_q[2];
    assign r3  = reg_q[3];
    assign r4  = reg_q[4];
    assign r5  = reg_q[5];
    assign r6  = reg_q[6];
    assign r7  = reg_q[7];
    assign r8  = reg_q[8];
    assign r9  = reg_q[9];
    assign r10 = reg_q[10];
    assign r11 = reg_q[11];
    assign r12 = reg_q[12];
    assign r13 = reg_q[13];
    assign r14 = reg_q[14];
    assign r15 = reg_q[15];

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: directed vector table, hand sequences, random traffic vs. a transaction model.
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  control;
    logic [15:0] bus;
    logic        wr_req;
    logic        wr_ack;
    logic        err;
    logic        clr_flags;
    logic [15:0] written;
    logic [15:0] r [16];

    int checks = 0;
    int failures = 0;

    // Transaction-level model: a handshake is either open or not.
    logic [15:0] m_r [16];
    logic [15:0] m_written;
    logic        m_open;
    logic        m_ack;
    logic        m_err;

    typedef struct {
        logic        req;
        logic [4:0]  ctrl;
        logic [15:0] data;
        logic        clr;
        logic        e_ack;
        logic        e_err;
        logic [15:0] e_written;
    } vec_t;

    vec_t vecs [10];

    regfile_writer #(.WIDTH(16), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .control(control), .bus(bus),
        .wr_req(wr_req), .wr_ack(wr_ack), .err(err), .clr_flags(clr_flags),
        .written(written),
        .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
        .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
        .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]),
        .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_written = '0;
        m_open    = 1'b0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_edge(input logic req, input logic [4:0] ctrl,
                              input logic [15:0] data, input logic clr);
        int code;
        code = int'(ctrl);
        if (clr) m_written = '0;
        if (!m_open && req) begin
            if (code >= 1 && code <= 16) begin
                m_r[code-1]         = data;
                m_written[code-1]   = 1'b1;
                m_err               = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_ack  = 1'b1;
            m_open = 1'b1;
        end else if (m_open && !req) begin
            m_open = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < 16; i++)
            if (bad < 0 && r[i] !== m_r[i]) bad = i;
        chk({tag, ".ack"}, 32'(wr_ack), 32'(m_ack));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".written"}, 32'(written), 32'(m_written));
        if (bad >= 0) chk($sformatf("%s.r%0d", tag, bad), 32'(r[bad]), 32'(m_r[bad]));
        else          chk({tag, ".regs"}, 32'(r[0]), 32'(m_r[0]));
    endtask

    // Drive inputs, take one rising edge, then compare 1 time unit later.
    task automatic step(input logic req, input logic [4:0] ctrl,
                        input logic [15:0] data, input logic clr, input string tag);
        wr_req    = req;
        control   = ctrl;
        bus       = data;
        clr_flags = clr;
        @(posedge clk);
        model_edge(req, ctrl, data, clr);
        #1;
        check_model(tag);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd1,  16'hA5A5, 1'b0, 1'b1, 1'b0, 16'h0001};
        vecs[1] = '{1'b0, 5'd1,  16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001};
        vecs[2] = '{1'b1, 5'd0,  16'h1111, 1'b0, 1'b1, 1'b1, 16'h0001};
        vecs[3] = '{1'b0, 5'd0,  16'h1111, 1'b0, 1'b0, 1'b0, 16'h0001};
        vecs[4] = '{1'b1, 5'd17, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h0001};
        vecs[5] = '{1'b0, 5'd17, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0001};
        vecs[6] = '{1'b1, 5'd31, 16'h3333, 1'b0, 1'b1, 1'b1, 16'h0001};
        vecs[7] = '{1'b0, 5'd31, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0001};
        vecs[8] = '{1'b1, 5'd16, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h8001};
        vecs[9] = '{1'b0, 5'd16, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

        rst_n = 1'b0; wr_req = 1'b0; control = '0; bus = '0; clr_flags = 1'b0;
        model_reset();
        #12;
        chk("reset.ack", 32'(wr_ack), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.written", 32'(written), 32'd0);
        chk("reset.r7", 32'(r[7]), 32'd0);
        #5 rst_n = 1'b1;

        // Directed table: basic write, invalid codes, top code, flag clear.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].req, vecs[i].ctrl, vecs[i].data, vecs[i].clr, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_ack", i), 32'(wr_ack), 32'(vecs[i].e_ack));
            chk($sformatf("vec%0d.tbl_err", i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d.tbl_written", i), 32'(written), 32'(vecs[i].e_written));
        end
        chk("basic.r0", 32'(r[0]), 32'h0000A5A5);
        chk("basic.r15", 32'(r[15]), 32'h00001234);

        // Sweep every register.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 5'(i + 1), 16'h1000 + 16'(i), 1'b0, "sweep_wr");
            step(1'b0, 5'd0, 16'h0000, 1'b0, "sweep_rel");
        end
        chk("sweep.written", 32'(written), 32'h0000FFFF);
        for (int i = 0; i < 16; i++)
            chk($sformatf("sweep.r%0d", i), 32'(r[i]), 32'h1000 + 32'(i));

        // Write and clear on the same edge.
        step(1'b1, 5'd9, 16'hC0DE, 1'b1, "clrwr");
        chk("clrwr.written", 32'(written), 32'h00000100);
        chk("clrwr.r8", 32'(r[8]), 32'h0000C0DE);
        step(1'b0, 5'd9, 16'h0000, 1'b0, "clrwr_rel");

        // Long request: only the first sampled code/data is written.
        step(1'b1, 5'd3, 16'hAAAA, 1'b0, "hold0");
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 1'b0, "hold");
            chk("hold.ack", 32'(wr_ack), 32'd1);
        end
        chk("hold.r2", 32'(r[2]), 32'h0000AAAA);
        step(1'b0, 5'd0, 16'h0000, 1'b0, "hold_rel");

        // Reset in the middle of an acknowledged handshake, request still high.
        step(1'b1, 5'd5, 16'hBEEF, 1'b0, "mid");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.ack", 32'(wr_ack), 32'd0);
        chk("midrst.err", 32'(err), 32'd0);
        chk("midrst.written", 32'(written), 32'd0);
        chk("midrst.r4", 32'(r[4]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd5, 16'hCAFE, 1'b0, "post_rst");
        chk("post_rst.r4", 32'(r[4]), 32'h0000CAFE);
        for (int i = 0; i < 3; i++) step(1'b1, 5'd6, 16'h5555, 1'b0, "post_hold");
        chk("post_rst.written", 32'(written), 32'h00000010);
        step(1'b0, 5'd0, 16'h0000, 1'b0, "post_rel");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        req;
            logic [4:0]  ctrl;
            logic        clr;
            req  = ($urandom_range(0, 99) < 55);
            ctrl = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(1, 16)) : 5'($urandom_range(0, 31));
            clr  = ($urandom_range(0, 19) == 0);
            step(req, ctrl, 16'($urandom), clr, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write side of the 16 x 16-bit general register file: captures the 16-bit bus into one of r0..r15 under a 5-bit register code and a four-phase req/ack handshake. It uses the same register-code encoding as the bus read mux (0 = none, 1..16 = r0..r15). Its r0..r15 outputs drive the mux's register inputs directly. It sits between the control unit, which issues codes and requests, and the bus read path.

## Interface
Parameters:
- WIDTH, 16, register and bus width
- NREGS, 16, number of registers; codes 1..NREGS are valid

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- control  in  5  target register code: 0 = none, 1..16 = r0..r15, 17..31 invalid
- bus  in  16  write data
- wr_req  in  1  write request, level, four-phase
- wr_ack  out  1  write acknowledge, registered
- err  out  1  acknowledged request had an invalid code, registered
- clr_flags  in  1  synchronous clear of the written[] vector
- written  out  16  bit i set when ri has been written since the last reset or clear
- r0..r15  out  16 each  register contents, registered

## Operation
- States: IDLE, ACK.
- IDLE, wr_req=0: hold all registers; wr_ack=0, err=0.
- IDLE, wr_req=1, control in 1..16:
  - On that edge, r[control-1] <= bus and written[control-1] <= 1.
  - wr_ack <= 1, err <= 0; go to ACK.
- IDLE, wr_req=1, control = 0 or 17..31:
  - No register or flag changes.
  - wr_ack <= 1, err <= 1; go to ACK.
- ACK: hold wr_ack and err. When wr_req is sampled 0: wr_ack <= 0, err <= 0, go to IDLE.
- control and bus are sampled only on the IDLE-to-ACK edge. Changes during ACK are ignored, so each request produces exactly one write.
- A new request is accepted only from IDLE. Minimum cycle: req high, ack, req low, ack low; 2 edges per write.
- clr_flags=1 clears all written bits on that edge.
  - Simultaneous write and clear: the flag of the written register ends at 1 (write wins); all other flags end at 0.
- Register contents are never cleared by clr_flags.
- Reset (asynchronous, any state, including mid-handshake):
  - state = IDLE; r0..r15 = 0; written = 0; wr_ack = 0; err = 0.
  - After rst_n rises with wr_req still high, the request is treated as new and is written once.

## Timing
- Write latency: wr_req and control sampled at edge N. Target register shows bus data after edge N, so the mux can read it in cycle N+1.
- wr_ack and err rise after edge N.
- wr_ack falls one edge after wr_req is first sampled low.
- All outputs are registered. No combinational path from any input to any output.
- Width rules: no arithmetic. Index = control - 1, 4 bits, computed only for codes 1..16.

## Structure
- Shared include/package `regfile_defs`, also used by the read mux:
  - code constants CODE_NONE=5'd0, CODE_R0=5'd1 .. CODE_R15=5'd16
  - CODE_MAX=5'd16
  - state encodings ST_IDLE, ST_ACK
- One natural sub-module: `reg16_cell`, a 16-bit register with load enable and async active-low clear. Instantiate it 16 times.
- Decode, flag vector and handshake FSM live in the top.

## Test plan
- Reset: assert rst_n=0 mid-ACK with wr_req=1 -> all r=0, written=0, wr_ack=0, err=0 immediately. On release with wr_req still high, exactly one write occurs.
- Basic write: control=5'd1, bus=16'hA5A5, wr_req=1 -> r0=16'hA5A5 and wr_ack=1 after the first edge; written=16'h0001. Drop wr_req -> wr_ack=0 one edge later.
- Sweep: write codes 1..16 with data 16'h1000+i -> ri = 16'h1000+i, written=16'hFFFF, no other register disturbed.
- Invalid codes: control=5'd0, then 5'd17, then 5'd31, with wr_req -> wr_ack=1, err=1, all registers and written unchanged.
- Hold wr_req=1 for 10 cycles while changing control and bus -> only the first sampled write is applied; wr_ack stays 1.
- Simultaneous clr_flags=1 and write to code 5'd9 with written=16'hFFFF -> written=16'h0100, r8 updated.
